hid_key_events: RTL and testbench

Converts level-style keyboard snapshots from the USB HID host core (modifier byte plus four key slots, refreshed on each `usb_report` pulse) into an ordered stream of discrete press/release events with a valid/ready handshake. Sits directly downstream of `usb_hid_host` in the `clk_usb` domain, alongside `hid_printer`. It feeds consumers that need key transitions rather than held-key lists, such as a keyboard matrix emulator or a scancode generator.

---
 rtl/hid_pkg.sv | 65 ++++++
 rtl/hid_event_fifo.sv | 46 ++++
 rtl/hid_key_events.sv | 171 +++++++++++++++++
 tb/tb_hid_key_events.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/hid_pkg.sv
// Shared types and constants for the HID keyboard event path.
// Snapshot layout, device types, FSM states and slot helpers.
package hid_pkg;

  localparam logic [1:0] TYP_NONE     = 2'd0;
  localparam logic [1:0] TYP_KEYBOARD = 2'd1;
  localparam logic [1:0] TYP_MOUSE    = 2'd2;
  localparam logic [1:0] TYP_GAMEPAD  = 2'd3;

  localparam logic [7:0] USAGE_MOD_BASE     = 8'hE0;
  localparam logic [7:0] USAGE_ERR_ROLLOVER = 8'h01;
  localparam logic [7:0] USAGE_UNDEF_MAX    = 8'h03;

  localparam int SNAP_W = 40;

  typedef struct packed {
    logic [7:0]      mod;
    logic [3:0][7:0] key;
  } snap_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MREL,
    S_KREL,
    S_MPRS,
    S_KPRS,
    S_COMMIT
  } state_e;

  function automatic logic has_code(
    input logic [7:0]      c,
    input logic [3:0][7:0] k
  );
    logic r;
    r = 1'b0;
    for (int j = 0; j < 4; j++)
      if (k[j] == c) r = 1'b1;
    return r;
  endfunction

  function automatic logic dup_below(
    input logic [3:0][7:0] k,
    input logic [1:0]      i
  );
    logic r;
    r = 1'b0;
    for (int j = 0; j < 4; j++)
      if (2'(j) < i && k[j] == k[i]) r = 1'b1;
    return r;
  endfunction

  function automatic logic is_phantom(
    input logic [3:0][7:0] k
  );
    logic r;
    r = 1'b0;
    for (int j = 0; j < 4; j++)
      if (k[j] >= USAGE_ERR_ROLLOVER &&
          k[j] <= USAGE_UNDEF_MAX)
        r = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/hid_event_fifo.sv
// First-word-fall-through event FIFO with full/empty flags.
// Extra pointer bit distinguishes full from empty.
module hid_event_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic         push_ok;
  logic         pop_ok;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = empty ? '0 : mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/hid_key_events.sv
// Diffs successive HID keyboard snapshots into press/release events.
// One slot is examined per cycle; a full FIFO stalls the scan.
module hid_key_events
  import hid_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] usb_type,
  input  logic       usb_report,
  input  logic [7:0] key_modifiers,
  input  logic [7:0] key1,
  input  logic [7:0] key2,
  input  logic [7:0] key3,
  input  logic [7:0] key4,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       ev_press,
  output logic [7:0] ev_code,
  output logic       busy
);

  state_e     state_q;
  logic [2:0] idx_q;
  snap_t      prev_q;
  snap_t      cur_q;
  snap_t      pend_q;
  logic       pend_v_q;
  logic       disc_q;

  snap_t      snap_in;
  logic       kb;
  logic       cap;
  logic [1:0] ki;

  logic       push_req;
  logic       push_press;
  logic [7:0] push_code;
  logic       last;
  state_e     nxt_scan;
  logic       stall;
  logic       push;
  logic       fifo_full;
  logic       fifo_empty;
  logic [8:0] fifo_dout;

  assign snap_in = '{mod: key_modifiers,
                     key: {key4, key3, key2, key1}};
  assign kb  = (usb_type == TYP_KEYBOARD);
  assign cap = usb_report && kb &&
               !is_phantom(snap_in.key);
  assign ki  = idx_q[1:0];

  always_comb begin
    push_req   = 1'b0;
    push_press = 1'b0;
    push_code  = 8'h00;
    last       = 1'b0;
    nxt_scan   = S_IDLE;
    case (state_q)
      S_MREL: begin
        push_req  = prev_q.mod[idx_q] &&
                    !cur_q.mod[idx_q];
        push_code = USAGE_MOD_BASE + {5'd0, idx_q};
        last      = (idx_q == 3'd7);
        nxt_scan  = S_KREL;
      end
      S_KREL: begin
        push_req  = (prev_q.key[ki] != 8'h00) &&
                    !has_code(prev_q.key[ki], cur_q.key);
        push_code = prev_q.key[ki];
        last      = (ki == 2'd3);
        nxt_scan  = S_MPRS;
      end
      S_MPRS: begin
        push_req   = !prev_q.mod[idx_q] &&
                     cur_q.mod[idx_q];
        push_press = 1'b1;
        push_code  = USAGE_MOD_BASE + {5'd0, idx_q};
        last       = (idx_q == 3'd7);
        nxt_scan   = S_KPRS;
      end
      S_KPRS: begin
        push_req   = (cur_q.key[ki] != 8'h00) &&
                     !has_code(cur_q.key[ki], prev_q.key) &&
                     !dup_below(cur_q.key, ki);
        push_press = 1'b1;
        push_code  = cur_q.key[ki];
        last       = (ki == 2'd3);
        nxt_scan   = S_COMMIT;
      end
      default: ;
    endcase
  end

  // A full FIFO blocks the push even if a pop happens this cycle.
  assign stall = push_req && fifo_full;
  assign push  = push_req && !fifo_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      prev_q   <= '0;
      cur_q    <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      disc_q   <= 1'b0;
    end else begin
      if (cap) begin
        pend_q   <= snap_in;
        pend_v_q <= 1'b1;
      end else if (state_q == S_LOAD) begin
        pend_v_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          idx_q <= '0;
          if (pend_v_q || cap) begin
            state_q <= S_LOAD;
            disc_q  <= 1'b0;
          end else if (!kb && prev_q != '0) begin
            state_q <= S_LOAD;
            disc_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          cur_q   <= disc_q ? '0 : pend_q;
          idx_q   <= '0;
          state_q <= S_MREL;
        end
        S_MREL, S_KREL, S_MPRS, S_KPRS: begin
          if (!stall) begin
            if (last) begin
              state_q <= nxt_scan;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        S_COMMIT: begin
          prev_q  <= cur_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  hid_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (9)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   ({push_press, push_code}),
    .pop   (ev_ready),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ev_valid = !fifo_empty;
  assign ev_press = fifo_dout[8];
  assign ev_code  = fifo_dout[7:0];
  assign busy     = (state_q != S_IDLE) || pend_v_q;

endmodule

// File: tb/tb_hid_key_events.sv
// Scoreboard bench for hid_key_events with a 4-deep event FIFO.
// Expected events are queued at stimulus time and popped on handshake.
module tb_hid_key_events;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] usb_type = 2'd1;
  logic       usb_report = 1'b0;
  logic [7:0] key_modifiers = 8'h00;
  logic [7:0] key1 = 8'h00;
  logic [7:0] key2 = 8'h00;
  logic [7:0] key3 = 8'h00;
  logic [7:0] key4 = 8'h00;
  logic       ev_valid;
  logic       ev_ready = 1'b1;
  logic       ev_press;
  logic [7:0] ev_code;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;
  logic [8:0] sb [$];

  hid_key_events #(
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .usb_type      (usb_type),
    .usb_report    (usb_report),
    .key_modifiers (key_modifiers),
    .key1          (key1),
    .key2          (key2),
    .key3          (key3),
    .key4          (key4),
    .ev_valid      (ev_valid),
    .ev_ready      (ev_ready),
    .ev_press      (ev_press),
    .ev_code       (ev_code),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic exp_ev(input logic p, input logic [7:0] c);
    sb.push_back({p, c});
  endtask

  task automatic send(
    input logic [7:0] m,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] c,
    input logic [7:0] d
  );
    key_modifiers = m;
    key1 = a;
    key2 = b;
    key3 = c;
    key4 = d;
    usb_report = 1'b1;
    @(posedge clk);
    #1 usb_report = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (!busy && !ev_valid && sb.size() == 0) ok = 1'b1;
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  // Monitor: every accepted event must match the scoreboard head.
  always @(negedge clk) begin
    if (!reset && ev_valid && ev_ready) begin
      if (sb.size() == 0) begin
        chk("sb_nonempty", 32'(sb.size()), 32'd1);
      end else begin
        chk("event", 32'({ev_press, ev_code}),
            32'(sb.pop_front()));
      end
    end
  end

  initial begin
    int c;
    int first_v;
    int busy_lo;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(ev_valid), 32'd0);
    chk("rst_press", 32'(ev_press), 32'd0);
    chk("rst_code",  32'(ev_code),  32'd0);
    chk("rst_busy",  32'(busy),     32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Single press: exact schedule of first event and busy fall
    exp_ev(1'b1, 8'h04);
    send(8'h00, 8'h04, 8'h00, 8'h00, 8'h00);
    first_v = -1;
    busy_lo = -1;
    for (c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (ev_valid && first_v < 0) first_v = c;
      if (!busy && busy_lo < 0) busy_lo = c;
    end
    chk("press_first_valid", 32'(first_v), 32'd23);
    chk("press_busy_fall",   32'(busy_lo), 32'd27);
    wait_idle("idle_press", 100);

    // Mixed: build prev {02; 04,05} then diff to {01; 05,06}
    exp_ev(1'b1, 8'hE1);
    exp_ev(1'b1, 8'h05);
    send(8'h02, 8'h04, 8'h05, 8'h00, 8'h00);
    wait_idle("idle_mix_a", 100);
    exp_ev(1'b0, 8'hE1);
    exp_ev(1'b0, 8'h04);
    exp_ev(1'b1, 8'hE0);
    exp_ev(1'b1, 8'h06);
    send(8'h01, 8'h05, 8'h06, 8'h00, 8'h00);
    wait_idle("idle_mix_b", 100);

    // Shuffle + duplicate
    exp_ev(1'b0, 8'hE0);
    exp_ev(1'b0, 8'h06);
    exp_ev(1'b1, 8'h04);
    send(8'h00, 8'h04, 8'h05, 8'h00, 8'h00);
    wait_idle("idle_shuf_a", 100);
    exp_ev(1'b1, 8'h07);
    send(8'h00, 8'h05, 8'h04, 8'h07, 8'h07);
    wait_idle("idle_shuf_b", 100);

    // Setup for disconnect: prev {02; 04}
    send(8'h00, 8'h05, 8'h04, 8'h07, 8'h00);
    wait_idle("idle_setup_a", 100);
    exp_ev(1'b0, 8'h05);
    exp_ev(1'b0, 8'h07);
    exp_ev(1'b1, 8'hE1);
    send(8'h02, 8'h04, 8'h00, 8'h00, 8'h00);
    wait_idle("idle_setup_b", 100);

    // Phantom report is discarded at capture
    send(8'h00, 8'h01, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    chk("phantom_busy", 32'(busy), 32'd0);
    wait_idle("idle_phantom", 100);

    // Disconnect releases everything still held
    exp_ev(1'b0, 8'hE1);
    exp_ev(1'b0, 8'h04);
    usb_type = 2'd0;
    wait_idle("idle_disc", 100);
    usb_type = 2'd1;
    @(negedge clk);

    // Back-pressure with 4-deep FIFO
    ev_ready = 1'b0;
    for (int i = 0; i < 8; i++) exp_ev(1'b1, 8'hE0 + 8'(i));
    for (int i = 4; i < 8; i++) exp_ev(1'b1, 8'(i));
    send(8'hFF, 8'h04, 8'h05, 8'h06, 8'h07);
    repeat (40) @(negedge clk);
    chk("bp_valid", 32'(ev_valid), 32'd1);
    chk("bp_busy",  32'(busy),     32'd1);
    chk("bp_hold0", 32'({ev_press, ev_code}), 32'h1E0);
    send(8'h00, 8'h04, 8'h00, 8'h00, 8'h00);
    for (int i = 1; i < 8; i++) exp_ev(1'b0, 8'hE0 + 8'(i));
    for (int i = 4; i < 8; i++) exp_ev(1'b0, 8'(i));
    exp_ev(1'b1, 8'h08);
    send(8'h01, 8'h08, 8'h00, 8'h00, 8'h00);
    repeat (10) @(negedge clk);
    chk("bp_hold1", 32'({ev_press, ev_code}), 32'h1E0);
    chk("bp_busy2", 32'(busy), 32'd1);
    ev_ready = 1'b1;
    wait_idle("idle_bp", 300);

    // Reset mid-scan (during KPRS)
    ev_ready = 1'b0;
    send(8'h03, 8'h09, 8'h0A, 8'h00, 8'h00);
    repeat (22) @(negedge clk);
    chk("pre_rst_valid", 32'(ev_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(ev_valid), 32'd0);
    chk("rst_mid_busy",  32'(busy),     32'd0);
    chk("rst_mid_code",  32'(ev_code),  32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    ev_ready = 1'b1;
    exp_ev(1'b1, 8'hE0);
    exp_ev(1'b1, 8'hE1);
    exp_ev(1'b1, 8'h09);
    exp_ev(1'b1, 8'h0A);
    send(8'h03, 8'h09, 8'h0A, 8'h00, 8'h00);
    wait_idle("idle_post_rst", 100);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
